// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: forwarding mux
// selects, the PC register address and the forwarding priority function.
package hazard_pkg;

  typedef logic [3:0] regAddr_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam regAddr_t REG_PC = 4'hF;

  // M beats W; R15 reads come from the PC path and are never forwarded.
  function automatic logic [1:0] fwdSelect(
    input regAddr_t ra,
    input logic     validM,
    input logic     regWriteM,
    input regAddr_t wa3M,
    input logic     validW,
    input logic     regWriteW,
    input regAddr_t wa3W
  );
    if (ra == REG_PC) return FWD_RF;
    if (validM && regWriteM && (ra == wa3M)) return FWD_MEM;
    if (validW && regWriteW && (ra == wa3W)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline/controller and the hazard unit. The master
// drives decode addresses and stage-tagged control; the slave returns hazards.
interface hazard_unit_if #(parameter int CNT_W = 16);
  import hazard_pkg::*;

  regAddr_t         RA1D, RA2D, WA3D;
  logic             RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchtakenE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchtakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchtakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit_scoreboard.sv
// Private E/M/W copies of the register addresses. A flush turns the D->E
// transfer into a bubble; E, M and W themselves always advance.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flushE,
  input  regAddr_t ra1D,
  input  regAddr_t ra2D,
  input  regAddr_t wa3D,
  output regAddr_t ra1E,
  output regAddr_t ra2E,
  output regAddr_t wa3E,
  output logic     validE,
  output regAddr_t wa3M,
  output logic     validM,
  output regAddr_t wa3W,
  output logic     validW
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra1E   <= '0;
      ra2E   <= '0;
      wa3E   <= '0;
      validE <= 1'b0;
      wa3M   <= '0;
      validM <= 1'b0;
      wa3W   <= '0;
      validW <= 1'b0;
    end else begin
      if (flushE) begin
        ra1E   <= '0;
        ra2E   <= '0;
        wa3E   <= '0;
        validE <= 1'b0;
      end else begin
        ra1E   <= ra1D;
        ra2E   <= ra2D;
        wa3E   <= wa3D;
        validE <= 1'b1;
      end
      wa3M   <= wa3E;
      validM <= validE;
      wa3W   <= wa3M;
      validW <= validM;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage ARM pipeline: operand forwarding, load-use
// stalls, PC-write/branch flushes and saturating stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  regAddr_t ra1E, ra2E, wa3E, wa3M, wa3W;
  logic     validE, validM, validW;

  logic ldrStallD;
  logic pcWrPendingF;
  logic stallF;
  logic flushE;

  logic [CNT_W-1:0] stallCountReg;
  logic [CNT_W-1:0] flushCountReg;

  hazard_scoreboard scoreboard (
    .clk    (clk),
    .reset  (reset),
    .flushE (flushE),
    .ra1D   (hz.RA1D),
    .ra2D   (hz.RA2D),
    .wa3D   (hz.WA3D),
    .ra1E   (ra1E),
    .ra2E   (ra2E),
    .wa3E   (wa3E),
    .validE (validE),
    .wa3M   (wa3M),
    .validM (validM),
    .wa3W   (wa3W),
    .validW (validW)
  );

  regAddr_t   raE [2];
  logic [1:0] fwdSel [2];

  assign raE[0] = ra1E;
  assign raE[1] = ra2E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gFwd
      assign fwdSel[gi] = fwdSelect(raE[gi], validM, hz.RegWriteM, wa3M,
                                    validW, hz.RegWriteW, wa3W);
    end
  endgenerate

  assign hz.ForwardAE = fwdSel[0];
  assign hz.ForwardBE = fwdSel[1];

  // Only a valid load in E can create a load-use hazard; bubbles never stall.
  assign ldrStallD    = validE && hz.MemtoRegE &&
                        ((hz.RA1D == wa3E) || (hz.RA2D == wa3E));
  assign pcWrPendingF = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign stallF       = ldrStallD | pcWrPendingF;
  assign flushE       = ldrStallD | hz.BranchtakenE;

  assign hz.StallF = stallF;
  assign hz.StallD = ldrStallD;
  assign hz.FlushD = pcWrPendingF | hz.PCSrcW | hz.BranchtakenE;
  assign hz.FlushE = flushE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCountReg <= '0;
      flushCountReg <= '0;
    end else begin
      if (stallF && (stallCountReg != '1)) stallCountReg <= stallCountReg + CNT_W'(1);
      if (flushE && (flushCountReg != '1)) flushCountReg <= flushCountReg + CNT_W'(1);
    end
  end

  assign hz.StallCount = stallCountReg;
  assign hz.FlushCount = flushCountReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: stimulus queues expected outputs,
// a monitor compares them against the DUT on the falling edge.
module tb_hazard_unit;

  localparam int CNT_W = 8;

  localparam logic [7:0] RWM  = 8'h80;
  localparam logic [7:0] RWW  = 8'h40;
  localparam logic [7:0] MEME = 8'h20;
  localparam logic [7:0] PCD  = 8'h10;
  localparam logic [7:0] PCE  = 8'h08;
  localparam logic [7:0] PCM  = 8'h04;
  localparam logic [7:0] PCW  = 8'h02;
  localparam logic [7:0] BT   = 8'h01;

  logic clk;
  logic reset;

  hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] expQ [$];
  string       nameQ [$];
  int          total = 0;
  int          bad = 0;
  event        asyncSample;

  task automatic step(input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa3, input logic [7:0] ctl);
    @(posedge clk);
    #1;
    hz.RA1D = ra1;
    hz.RA2D = ra2;
    hz.WA3D = wa3;
    {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.PCSrcD,
     hz.PCSrcE, hz.PCSrcM, hz.PCSrcW, hz.BranchtakenE} = ctl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 4'h0, 8'h00);
  endtask

  // flags = {StallF, StallD, FlushD, FlushE}
  task automatic want(input string name, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] flags, input logic [7:0] sc, input logic [7:0] fc);
    expQ.push_back({fa, fb, flags, sc, fc});
    nameQ.push_back(name);
  endtask

  initial begin : monitor
    logic [23:0] exp;
    logic [23:0] act;
    string       nm;
    forever begin
      @(negedge clk or asyncSample);
      while (expQ.size() > 0) begin
        exp = expQ.pop_front();
        nm  = nameQ.pop_front();
        act = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.FlushD,
               hz.FlushE, hz.StallCount, hz.FlushCount};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL %s: got fa=%b fb=%b flags=%b sc=%h fc=%h, want fa=%b fb=%b flags=%b sc=%h fc=%h",
                   nm, act[23:22], act[21:20], act[19:16], act[15:8], act[7:0],
                   exp[23:22], exp[21:20], exp[19:16], exp[15:8], exp[7:0]);
        end else begin
          $display("ok   %s: fa=%b fb=%b flags=%b sc=%h fc=%h",
                   nm, act[23:22], act[21:20], act[19:16], act[15:8], act[7:0]);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    hz.RA1D = '0; hz.RA2D = '0; hz.WA3D = '0;
    {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.PCSrcD,
     hz.PCSrcE, hz.PCSrcM, hz.PCSrcW, hz.BranchtakenE} = '0;

    // Under reset nothing may forward or stall regardless of inputs
    step(4'h0, 4'h0, 4'h0, RWM | RWW | MEME);
    want("rst_hold", 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00);
    step(4'h0, 4'h0, 4'h0, 8'h00);
    reset = 1'b0;
    idle(3);

    // ADD R1 ; ADD R2,R1,R3
    step(4'h2, 4'h3, 4'h1, 8'h00);
    want("add_dec", 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00);
    step(4'h1, 4'h3, 4'h2, 8'h00);
    step(4'h0, 4'h0, 4'h0, RWM);
    want("add_fwdA_mem", 2'b10, 2'b00, 4'b0000, 8'h00, 8'h00);
    idle(3);

    // Writer R4, writer R4, reader R4 (B), reader R4 (B)
    step(4'h0, 4'h0, 4'h4, 8'h00);
    step(4'h0, 4'h0, 4'h4, 8'h00);
    step(4'h0, 4'h4, 4'h0, 8'h00);
    step(4'h0, 4'h4, 4'h0, RWM | RWW);
    want("fwdB_m_over_w", 2'b00, 2'b10, 4'b0000, 8'h00, 8'h00);
    step(4'h0, 4'h0, 4'h0, RWM | RWW);
    want("fwdB_wb", 2'b10, 2'b01, 4'b0000, 8'h00, 8'h00);
    idle(3);

    // LDR R5 ; ADD R6,R5,R0
    step(4'h0, 4'h0, 4'h5, 8'h00);
    want("ldr_dec", 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00);
    step(4'h5, 4'h0, 4'h6, MEME);
    want("ldr_stall", 2'b00, 2'b00, 4'b1101, 8'h00, 8'h00);
    step(4'h5, 4'h0, 4'h6, RWM);
    want("ldr_bubble", 2'b00, 2'b00, 4'b0000, 8'h01, 8'h01);
    step(4'h0, 4'h0, 4'h0, RWW);
    want("ldr_fwd", 2'b01, 2'b00, 4'b0000, 8'h01, 8'h01);
    idle(3);

    // Branch taken alone, then during a load-use stall
    step(4'h0, 4'h0, 4'h0, BT);
    want("br_flush", 2'b00, 2'b00, 4'b0011, 8'h01, 8'h01);
    step(4'h0, 4'h0, 4'h0, MEME);
    want("br_bubble", 2'b00, 2'b00, 4'b0000, 8'h01, 8'h02);
    step(4'h0, 4'h0, 4'h7, 8'h00);
    step(4'h7, 4'h0, 4'h0, MEME | BT);
    want("br_ldr", 2'b00, 2'b00, 4'b1111, 8'h01, 8'h02);
    step(4'h0, 4'h0, 4'h0, MEME);
    want("br_ldr_after", 2'b00, 2'b00, 4'b0000, 8'h02, 8'h03);
    idle(3);

    // PC write walking D->E->M->W, with R15 read in E while M writes R15
    step(4'h0, 4'h0, 4'h0, PCD);
    want("pc_d", 2'b00, 2'b00, 4'b1010, 8'h02, 8'h03);
    step(4'h0, 4'h0, 4'hF, PCE);
    want("pc_e", 2'b00, 2'b00, 4'b1010, 8'h03, 8'h03);
    step(4'hF, 4'h0, 4'h0, PCM);
    want("pc_m", 2'b00, 2'b00, 4'b1010, 8'h04, 8'h03);
    step(4'h0, 4'h0, 4'h0, PCW | RWM);
    want("pc_w_r15_nofwd", 2'b00, 2'b00, 4'b0010, 8'h05, 8'h03);
    step(4'h0, 4'h0, 4'h0, 8'h00);
    want("pc_done", 2'b00, 2'b00, 4'b0000, 8'h05, 8'h03);

    // 2^CNT_W+5 stall cycles saturate the stall counter
    for (int i = 0; i < (1 << CNT_W) + 4; i++) step(4'h0, 4'h0, 4'h0, PCD);
    step(4'h0, 4'h0, 4'h0, PCD);
    want("stall_sat", 2'b00, 2'b00, 4'b1010, 8'hFF, 8'h03);

    // Load-use stall with live forwarding, then reset mid-cycle
    step(4'h0, 4'h0, 4'h3, 8'h00);
    step(4'h3, 4'h0, 4'h9, 8'h00);
    step(4'h9, 4'h0, 4'h0, MEME | RWM);
    want("mid_stall", 2'b10, 2'b00, 4'b1101, 8'hFF, 8'h03);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    want("rst_async", 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00);
    ->asyncSample;
    step(4'h9, 4'h0, 4'h0, MEME | RWM);
    want("rst_held", 2'b00, 2'b00, 4'b0000, 8'h00, 8'h00);
    step(4'h0, 4'h0, 4'h0, 8'h00);
    reset = 1'b0;
    idle(2);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
